shift_unit_pipe: RTL
====================

Name: shift_unit_pipe

Overview:
Parametrised, pipelined barrel shifter for the RV32I execute path and wider variants. Supports SLL/SRL/SRA plus ROL/ROR (Zbb-style) with a valid/ready handshake, backpressure, tag passthrough and synchronous flush. Sits beside the ALU; the issue stage drives the input side, writeback/forwarding consumes the output side.

Parameters:
XLEN, 32, data width; power of two, 8..64.
STAGES, 2, register stages (latency); legal range 1..$clog2(XLEN).
TAG_W, 5, width of the sideband tag (e.g. rd index) carried alongside the data.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
flush  in  1  synchronous kill of all in-flight ops.
in_valid  in  1  input op present.
in_ready  out  1  block accepts the input op this cycle.
in_op  in  3  000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, others illegal.
in_a  in  XLEN  operand to shift.
in_b  in  XLEN  shift amount; only bits [$clog2(XLEN)-1:0] are used.
in_tag  in  TAG_W  sideband, returned unchanged.
out_valid  out  1  result present.
out_ready  in  1  consumer accepts the result.
out_data  out  XLEN  shifted result.
out_tag  out  TAG_W  tag of the op in out_data.

Behaviour:
- Reset (async, rst_n low): all stage valids clear, so out_valid=0. out_data=0 and out_tag=0. Takes effect immediately, not at the next edge. Ops in flight are lost.
- Shift amount: SH = in_b[$clog2(XLEN)-1:0]. Upper bits are ignored, and SH=0 returns in_a for every legal op.
- SLL fills with zeros. SRL fills with zeros. SRA fills with in_a[XLEN-1]. ROL/ROR rotate modulo XLEN.
- Illegal op: out_data=0, tag is still passed through, and out_valid behaves as for a legal op.
- Structure: $clog2(XLEN) barrel levels, where level k shifts by 2^k. Level k is placed in stage floor(k*STAGES/$clog2(XLEN)). Each stage ends in a register holding data, op, the remaining shamt bits, tag and valid. The final stage register drives the outputs directly, with no combinational path from in_* to out_*.
- Latency: an op accepted at edge N appears with out_valid=1 after edge N+STAGES-1, i.e. STAGES cycles later, if no stall occurs.
- Throughput: one op per cycle.
- Handshake:
  - Global advance: adv = out_ready | ~out_valid.
  - All stages shift together when adv=1 and hold when adv=0.
  - in_ready = adv & ~flush.
  - Input is accepted when in_valid & in_ready.
  - Bubbles are allowed; the pipeline does not compact bubbles while stalled.
- Output stability: while out_valid=1 and out_ready=0, out_data and out_tag hold stable and in_ready=0.
- Flush: on the edge where flush=1, all stage valids clear. Data registers may keep stale values. flush has priority over in_valid (nothing is accepted) and over a simultaneous output transfer (that result is dropped).
- Ordering: results leave in acceptance order and are never duplicated.
- Inputs are sampled only on acceptance. Changing in_* while in_ready=0 has no effect.

Decomposition:
- Package shift_pkg holds the op encodings (SHIFT_SLL..SHIFT_ROR), the op width constant (3), and a function computing the stage index of a level.
- One sub-module, shift_level, implements one barrel level for all five ops. Its parameters are XLEN and SHIFT_BY. It is purely combinational: it takes data, op and one shamt bit and produces data. The top instantiates $clog2(XLEN) of them and places the pipeline registers between them.
- RTL estimate: roughly 200 lines in total.

Test Plan:
- XLEN=32, STAGES=2. SLL a=0x00000001, b=31, tag=7 -> two cycles later out_data=0x80000000, out_tag=7. b=0xFFFFFFE5 (SH=5) on a=1 -> 0x00000020.
- SRA a=0x80000000, b=4 -> 0xF8000000. SRL with the same operands -> 0x08000000. SRA a=0x7FFFFFFF, b=31 -> 0x00000000.
- ROR a=0x000000F1, b=4 -> 0x1000000F. ROL a=0x80000001, b=1 -> 0x00000003. ROL with b=0 -> a unchanged. op=111 -> 0x00000000 with tag passed through.
- Issue 6 back-to-back ops with tags 0..5 and hold out_ready=0 for 3 cycles after the first result -> in_ready=0 and out_data stable during the stall. All 6 tags then emerge in order, with none lost or duplicated.
- With 2 ops in flight, assert flush for 1 cycle while in_valid=1 -> the input is not accepted and no out_valid appears for the flushed ops. The next op issued afterwards completes with correct latency.
- Pulse rst_n low mid-stream, asynchronously between edges -> out_valid, out_data and out_tag go to 0 immediately. After release, only newly issued ops appear.
- Repeat the directed cases with STAGES=1 and STAGES=5, and XLEN=64 with STAGES=3, against a reference model using random ops and random backpressure.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined shifter: op encodings and level-to-stage mapping.
// No logic, no latency; no handshake of its own.
// Imported by shift_level and shift_unit_pipe.
package shift_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        SHIFT_SLL = 3'b000,
        SHIFT_SRL = 3'b001,
        SHIFT_SRA = 3'b010,
        SHIFT_ROL = 3'b011,
        SHIFT_ROR = 3'b100
    } shift_op_e;

    // Levels are spread evenly over the stages; every stage gets at least one level.
    function automatic int level_stage(input int level, input int stages, input int levels);
        return (level * stages) / levels;
    endfunction

endpackage

// File: rtl/shift_level.sv
// One barrel level: conditionally shifts/rotates by SHIFT_BY for all five ops.
// Purely combinational, zero latency.
// No handshake; the enclosing pipeline owns flow control.
module shift_level
    import shift_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int SHIFT_BY = 1
) (
    input  logic [XLEN-1:0] in_data,
    input  logic [OP_W-1:0] op,
    input  logic            sh_bit,
    output logic [XLEN-1:0] out_data
);

    logic [XLEN-1:0] sll_dat;
    logic [XLEN-1:0] srl_dat;
    logic [XLEN-1:0] sra_dat;
    logic [XLEN-1:0] rol_dat;
    logic [XLEN-1:0] ror_dat;

    always_comb begin
        sll_dat = in_data << SHIFT_BY;
        srl_dat = in_data >> SHIFT_BY;
        sra_dat = $unsigned($signed(in_data) >>> SHIFT_BY);
        rol_dat = {in_data[XLEN-SHIFT_BY-1:0], in_data[XLEN-1:XLEN-SHIFT_BY]};
        ror_dat = {in_data[SHIFT_BY-1:0], in_data[XLEN-1:SHIFT_BY]};

        // Illegal ops collapse to zero at every level, so the final result is zero.
        out_data = '0;
        case (op)
            SHIFT_SLL: out_data = sh_bit ? sll_dat : in_data;
            SHIFT_SRL: out_data = sh_bit ? srl_dat : in_data;
            SHIFT_SRA: out_data = sh_bit ? sra_dat : in_data;
            SHIFT_ROL: out_data = sh_bit ? rol_dat : in_data;
            SHIFT_ROR: out_data = sh_bit ? ror_dat : in_data;
            default:   out_data = '0;
        endcase
    end

endmodule

// File: rtl/shift_unit_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROL/ROR) with tag passthrough and synchronous flush.
// Latency STAGES cycles, one op per cycle; outputs come straight from the last stage register.
// Whole pipe advances when out_ready | ~out_valid, otherwise holds; in_ready = advance & ~flush.
module shift_unit_pipe
    import shift_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_data,
    output logic [TAG_W-1:0] out_tag
);

    localparam int SH_W = $clog2(XLEN);

    typedef struct packed {
        logic             vld;
        logic [OP_W-1:0]  op;
        logic [SH_W-1:0]  sh;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  dat;
    } stage_t;

    stage_t          st_in  [STAGES];
    stage_t          st_q   [STAGES];
    logic [XLEN-1:0] st_dat [STAGES];
    logic [XLEN-1:0] lvl_in [SH_W];
    logic [XLEN-1:0] lvl_out[SH_W];
    logic            adv;
    logic            unused_bits;

    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv & ~flush;

    // A stage only loads when adv & ~flush, so in_valid alone marks an accepted op.
    assign st_in[0] = '{vld: in_valid, op: in_op, sh: in_b[SH_W-1:0], tag: in_tag, dat: in_a};

    for (genvar s = 1; s < STAGES; s++) begin : g_stage_in
        assign st_in[s] = st_q[s-1];
    end

    for (genvar k = 0; k < SH_W; k++) begin : g_lvl
        localparam int S     = level_stage(k, STAGES, SH_W);
        localparam bit FIRST = (k == 0) || (level_stage(k - 1, STAGES, SH_W) != S);
        localparam bit LAST  = (k == SH_W - 1) || (level_stage(k + 1, STAGES, SH_W) != S);

        if (FIRST) begin : g_first
            assign lvl_in[k] = st_in[S].dat;
        end else begin : g_chain
            assign lvl_in[k] = lvl_out[k-1];
        end

        shift_level #(
            .XLEN     (XLEN),
            .SHIFT_BY (1 << k)
        ) u_level (
            .in_data  (lvl_in[k]),
            .op       (st_in[S].op),
            .sh_bit   (st_in[S].sh[k]),
            .out_data (lvl_out[k])
        );

        if (LAST) begin : g_last
            assign st_dat[S] = lvl_out[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < STAGES; s++) begin
                st_q[s] <= '0;
            end
        end else if (flush) begin
            for (int s = 0; s < STAGES; s++) begin
                st_q[s].vld <= 1'b0;
            end
        end else if (adv) begin
            for (int s = 0; s < STAGES; s++) begin
                st_q[s] <= '{vld: st_in[s].vld, op: st_in[s].op, sh: st_in[s].sh,
                             tag: st_in[s].tag, dat: st_dat[s]};
            end
        end
    end

    assign out_valid = st_q[STAGES-1].vld;
    assign out_data  = st_q[STAGES-1].dat;
    assign out_tag   = st_q[STAGES-1].tag;

    // Upper shift-amount bits are ignored; op/shamt are dead after the last level.
    assign unused_bits = ^{in_b[XLEN-1:SH_W], st_q[STAGES-1].op, st_q[STAGES-1].sh};

endmodule
